// File: rtl/bpf_pkg.sv
// Shared definitions for the BPF packet front-end and the filter core.
// Holds the loader state encoding and the packet address/length widths
// that the core also uses to bound its packet-load address range.
package bpf_pkg;

    localparam int BPF_PKT_ADDR_W = 8;
    localparam int BPF_PKT_LEN_W  = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/bpf_pkt_ram.sv
// Packet RAM: 2**ADDR_W bytes, one synchronous write port and one
// registered read port. Not reset, so it maps onto block RAM.
// Ports:
//   clk               clock
//   wr_en/wr_addr/wr_data   write port
//   rd_addr           read address (cycle N)
//   rd_data           read data (cycle N+1)
module bpf_pkt_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [0:(2**ADDR_W)-1];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bpf_pkt_loader.sv
// Packet front-end for the BPF core. Loads one packet from a byte stream
// into the packet RAM, pulses cpu_start, serves the core's packet reads
// (bytes beyond the stored length read as 0x00), then captures the
// core's verdict and presents it downstream with the stored length.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   packet byte stream
//   cpu_start, cpu_done, cpu_accept     core control and verdict
//   cpu_rd_addr, cpu_rd_data            core packet read port (1-cycle)
//   pkt_len                             length of the current packet
//   verdict_valid/ready/accept/len/trunc  verdict output handshake
module bpf_pkt_loader
    import bpf_pkg::*;
#(
    parameter int ADDR_W = BPF_PKT_ADDR_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              cpu_start,
    input  logic              cpu_done,
    input  logic              cpu_accept,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic [7:0]        cpu_rd_data,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              verdict_valid,
    input  logic              verdict_ready,
    output logic              verdict_accept,
    output logic [LEN_W-1:0]  verdict_len,
    output logic              verdict_trunc
);

    localparam logic [LEN_W-1:0] ONE     = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] MAX_LEN = ONE << ADDR_W;

    ldr_state_t        state;
    ldr_state_t        state_next;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  count_next;
    logic              trunc;
    logic              trunc_next;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              capture;
    logic              release_verdict;
    logic              beat;
    logic              rd_in_range;
    logic [7:0]        ram_rd_data;

    assign beat = in_valid && in_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, byte counter, truncation and RAM write control.
    always_comb begin
        state_next      = state;
        count_next      = count;
        trunc_next      = trunc;
        wr_en           = 1'b0;
        wr_addr         = count[ADDR_W-1:0];
        capture         = 1'b0;
        release_verdict = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    wr_en      = 1'b1;
                    wr_addr    = {ADDR_W{1'b0}};
                    count_next = ONE;
                    trunc_next = 1'b0;
                    state_next = in_last ? RUN : LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                if (beat) begin
                    // Once the RAM is full further bytes are dropped and
                    // the count holds at MAX_LEN.
                    if (count < MAX_LEN) begin
                        wr_en      = 1'b1;
                        count_next = count + ONE;
                    end else begin
                        trunc_next = 1'b1;
                    end
                    state_next = in_last ? RUN : LOAD;
                end else begin
                    state_next = LOAD;
                end
            end
            RUN: begin
                if (cpu_done) begin
                    capture    = 1'b1;
                    state_next = REPORT;
                end else begin
                    state_next = RUN;
                end
            end
            REPORT: begin
                if (verdict_ready) begin
                    release_verdict = 1'b1;
                    count_next      = {LEN_W{1'b0}};
                    trunc_next      = 1'b0;
                    state_next      = IDLE;
                end else begin
                    state_next = REPORT;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = {LEN_W{1'b0}};
                trunc_next = 1'b0;
            end
        endcase
    end

    // Datapath registers: counter, handshake/start flags, read mask, verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= {LEN_W{1'b0}};
            trunc          <= 1'b0;
            in_ready       <= 1'b1;
            cpu_start      <= 1'b0;
            rd_in_range    <= 1'b0;
            verdict_valid  <= 1'b0;
            verdict_accept <= 1'b0;
            verdict_len    <= {LEN_W{1'b0}};
            verdict_trunc  <= 1'b0;
        end else begin
            count       <= count_next;
            trunc       <= trunc_next;
            // in_ready depends only on the upcoming state.
            in_ready    <= (state_next == IDLE) || (state_next == LOAD);
            cpu_start   <= (state_next == RUN) && (state != RUN);
            // Mask decision is taken alongside the RAM read so that stale
            // bytes past the current length never reach the core.
            rd_in_range <= (LEN_W'(cpu_rd_addr) < count);
            if (capture) begin
                verdict_valid  <= 1'b1;
                verdict_accept <= cpu_accept;
                verdict_len    <= count;
                verdict_trunc  <= trunc;
            end else if (release_verdict) begin
                verdict_valid  <= 1'b0;
                verdict_accept <= 1'b0;
                verdict_len    <= {LEN_W{1'b0}};
                verdict_trunc  <= 1'b0;
            end
        end
    end

    assign pkt_len     = count;
    assign cpu_rd_data = rd_in_range ? ram_rd_data : 8'h00;

    bpf_pkt_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (cpu_rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule
